// File: rtl/flash_reader_pkg.sv
// flash_reader_pkg: shared states, SPI READ command constants and address helper
package flash_reader_pkg;

    typedef enum logic [2:0] {
        STARTUP,
        IDLE,
        SEND,
        RECV,
        DONE,
        HOLD
    } state_t;

    localparam logic [7:0] READ_OP   = 8'h03;
    localparam int         CMD_BITS  = 32;
    localparam int         DATA_BITS = 16;

    function automatic logic [23:0] byte_addr(input logic [23:0] base, input logic [23:0] addr);
        return base + {addr[22:0], 1'b0};
    endfunction

endpackage

// File: rtl/flash_sck_gen.sv
// flash_sck_gen: mode-0 SPI clock with one-cycle strobes ahead of each SCK edge
module flash_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int W = $clog2(CLK_DIV + 1);

    logic [W-1:0] cnt;
    logic         tick;

    assign tick = run && cnt == W'(CLK_DIV - 1);
    assign rise = tick && !sck;
    assign fall = tick && sck;

    // Half-period counter; SCK parks low whenever the link is not running
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            sck <= !sck;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/flash_reader.sv
// flash_reader: SPI flash READ engine returning one 16-bit word per request
module flash_reader
    import flash_reader_pkg::*;
#(
    parameter int          CLK_DIV        = 2,
    parameter logic [23:0] BASE_ADDR      = 24'h200000,
    parameter int          STARTUP_CYCLES = 10000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] flash_addr,
    input  logic        flash_enable,
    output logic [15:0] data_out,
    output logic        data_ready,
    output logic        flash_cs_n,
    output logic        flash_sck,
    output logic        flash_mosi,
    input  logic        flash_miso
);

    state_t      state, next;
    logic [31:0] cnt;
    logic [4:0]  bits;
    logic [31:0] sh;
    logic [31:0] cmd;
    logic [15:0] rx;
    logic        run, rise, fall;

    assign run        = state == SEND || state == RECV;
    assign flash_cs_n = !run;
    assign data_ready = state == IDLE || state == HOLD;
    assign cmd        = {READ_OP, byte_addr(BASE_ADDR, flash_addr)};

    flash_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
        .clk  (clk),
        .reset(reset),
        .run  (run),
        .sck  (flash_sck),
        .rise (rise),
        .fall (fall)
    );

    // State register
    always_ff @(posedge clk) begin
        state <= reset ? STARTUP : next;
    end

    // Next-state: bit phases end on the falling edge that closes their last bit
    always_comb begin
        next = state;
        case (state)
            STARTUP: if (cnt == 32'(STARTUP_CYCLES - 1)) next = IDLE;
            IDLE:    if (flash_enable) next = SEND;
            SEND:    if (fall && bits == 5'(CMD_BITS - 1)) next = RECV;
            RECV:    if (fall && bits == 5'(DATA_BITS - 1)) next = DONE;
            DONE:    if (cnt == 32'(2 * CLK_DIV - 1)) next = HOLD;
            HOLD:    if (!flash_enable) next = IDLE;
            default: next = STARTUP;
        endcase
    end

    // Datapath: command shifter, receive shifter and the published word
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            bits       <= '0;
            sh         <= '0;
            rx         <= '0;
            flash_mosi <= 1'b0;
            data_out   <= '0;
        end else begin
            cnt <= (state == STARTUP || state == DONE) ? cnt + 32'd1 : '0;
            if (state == IDLE && flash_enable) begin
                bits       <= '0;
                sh         <= {cmd[30:0], 1'b0};
                flash_mosi <= cmd[31];
            end
            if (fall) begin
                bits       <= bits + 5'd1;
                sh         <= {sh[30:0], 1'b0};
                flash_mosi <= sh[31];
            end
            if (rise && state == RECV) rx <= {rx[14:0], flash_miso};
            if (state == DONE && next == HOLD) data_out <= rx;
        end
    end

endmodule

// File: tb/tb_flash_reader.sv
// tb_flash_reader: directed vectors plus handshake, hold, reset and wrap sequences
module tb_flash_reader;

    localparam int CLK_DIV = 2;
    localparam int STARTUP = 20;
    localparam int MAX_LAT = 48 * 2 * CLK_DIV + 2 * CLK_DIV + 4;

    logic        clk = 0, reset = 1, flash_enable = 0, flash_miso = 0;
    logic [23:0] flash_addr = '0;
    logic [15:0] data_out;
    logic        data_ready, flash_cs_n, flash_sck, flash_mosi;

    logic        enable2 = 0;
    logic [23:0] addr2 = '0;
    logic [15:0] data_out2;
    logic        ready2, cs2, sck2, mosi2;

    int          applied = 0, miscompares = 0;
    int          bitcnt = 0, frames = 0, cnt2 = 0;
    logic [31:0] cmd = '0, cmd2 = '0;
    logic [15:0] w;

    typedef struct {
        logic [23:0] addr;
        logic [31:0] cmd;
        logic [15:0] data;
    } vec_t;
    vec_t vecs[7];

    flash_reader #(.CLK_DIV(CLK_DIV), .BASE_ADDR(24'h200000), .STARTUP_CYCLES(STARTUP)) dut (
        .clk(clk), .reset(reset), .flash_addr(flash_addr), .flash_enable(flash_enable),
        .data_out(data_out), .data_ready(data_ready), .flash_cs_n(flash_cs_n),
        .flash_sck(flash_sck), .flash_mosi(flash_mosi), .flash_miso(flash_miso)
    );

    flash_reader #(.CLK_DIV(CLK_DIV), .BASE_ADDR(24'hFFFFFE), .STARTUP_CYCLES(STARTUP)) dut_wrap (
        .clk(clk), .reset(reset), .flash_addr(addr2), .flash_enable(enable2),
        .data_out(data_out2), .data_ready(ready2), .flash_cs_n(cs2),
        .flash_sck(sck2), .flash_mosi(mosi2), .flash_miso(1'b0)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [23:0] a);
        return a == 24'h200010 ? 16'hA55A : a[15:0] ^ 16'h1234;
    endfunction

    always @(negedge flash_cs_n) frames++;

    always @(negedge flash_cs_n or posedge flash_sck) begin
        if (!flash_sck) begin
            bitcnt = 0;
            cmd    = '0;
        end else if (!flash_cs_n) begin
            if (bitcnt < 32) cmd = {cmd[30:0], flash_mosi};
            bitcnt++;
        end
    end

    always @(negedge flash_sck) begin
        if (!flash_cs_n && bitcnt >= 32 && bitcnt < 48) begin
            w          = mem_word(cmd[23:0]);
            flash_miso = w[47 - bitcnt];
        end
    end

    always @(negedge cs2 or posedge sck2) begin
        if (!sck2) begin
            cnt2 = 0;
            cmd2 = '0;
        end else if (!cs2) begin
            if (cnt2 < 32) cmd2 = {cmd2[30:0], mosi2};
            cnt2++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_read(input logic [23:0] a, input bit drop, output int lat);
        flash_addr   = a;
        flash_enable = 1;
        lat          = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (data_ready && lat < 1000);
        while (!data_ready && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        if (drop) flash_enable = 0;
    endtask

    task automatic startup_check(input string name);
        int   n   = 0;
        logic bad = 0;
        while (!data_ready && n < STARTUP + 10) begin
            @(negedge clk);
            n++;
            if (flash_cs_n !== 1'b1 || flash_sck !== 1'b0) bad = 1;
        end
        check({name, "_cycles"}, 32'(n == STARTUP || n == STARTUP + 1), 1);
        check({name, "_cs_high"}, 32'(bad), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, f, n;
        vecs[0] = '{24'h000008, 32'h03200010, 16'hA55A};
        vecs[1] = '{24'h000000, 32'h03200000, 16'h1234};
        vecs[2] = '{24'h000001, 32'h03200002, 16'h1236};
        vecs[3] = '{24'h000002, 32'h03200004, 16'h1230};
        vecs[4] = '{24'h000003, 32'h03200006, 16'h1232};
        vecs[5] = '{24'h7FFFFF, 32'h031FFFFE, 16'hEDCA};
        vecs[6] = '{24'h800005, 32'h0320000A, 16'h123E};

        repeat (3) @(negedge clk);
        check("reset_outputs", {data_ready, flash_cs_n, flash_sck, flash_mosi, data_out},
              {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
        reset = 0;
        startup_check("startup");

        for (int i = 0; i < 7; i++) begin
            f = frames;
            do_read(vecs[i].addr, 1, lat);
            check($sformatf("vec%0d_data", i), data_out, vecs[i].data);
            check($sformatf("vec%0d_cmd", i), cmd, vecs[i].cmd);
            check($sformatf("vec%0d_latency", i), 32'(lat <= MAX_LAT), 1);
            check($sformatf("vec%0d_frames", i), frames, f + 1);
            @(negedge clk);
        end

        do_read(24'h000002, 0, lat);
        check("hold_data", data_out, 16'h1230);
        f = frames;
        repeat (500) @(negedge clk);
        check("hold_no_reserve", frames, f);
        check("hold_ready", {data_ready, flash_cs_n}, 2'b11);
        flash_enable = 0;
        repeat (2) @(negedge clk);
        check("hold_released_idle", frames, f);
        do_read(24'h000003, 1, lat);
        check("hold_next_frame", frames, f + 1);
        check("hold_next_data", data_out, 16'h1232);
        @(negedge clk);

        f            = frames;
        flash_addr   = 24'h000001;
        flash_enable = 1;
        repeat (2) @(negedge clk);
        check("busy_after_accept", data_ready, 0);
        flash_addr = 24'h000003;
        repeat (20) @(negedge clk);
        check("data_stable_busy", data_out, 16'h1232);
        flash_enable = 0;
        n = 0;
        while (!data_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("early_drop_data", data_out, 16'h1236);
        check("early_drop_cmd", cmd, 32'h03200002);
        repeat (50) @(negedge clk);
        check("early_drop_single_frame", frames, f + 1);
        check("early_drop_idle", {data_ready, flash_cs_n}, 2'b11);

        flash_addr   = 24'h000008;
        flash_enable = 1;
        repeat (2) @(negedge clk);
        n = 0;
        while (bitcnt < 40 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reached_recv", 32'(bitcnt >= 40 && !flash_cs_n), 1);
        reset        = 1;
        flash_enable = 0;
        @(negedge clk);
        check("midrecv_reset", {flash_cs_n, data_ready, data_out}, {1'b1, 1'b0, 16'h0000});
        @(negedge clk);
        reset = 0;
        startup_check("restart");
        check("restart_data_cleared", data_out, 16'h0000);
        do_read(24'h000008, 1, lat);
        check("restart_read", data_out, 16'hA55A);
        @(negedge clk);

        addr2   = 24'h000001;
        enable2 = 1;
        n       = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready2 && n < 1000);
        while (!ready2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        enable2 = 0;
        check("wrap_cmd", cmd2, 32'h03000000);
        check("wrap_latency", 32'(n <= MAX_LAT), 1);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
